// File: rtl/mem_port_arbiter_pkg.sv
// Shared arbiter definitions: FSM state codes, owner codes and the abort read pattern.
// No logic; imported by the arbiter, its interface users and the bench.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_BUSY = 2'd1,
        ARB_DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        ARB_OWN_INST = 1'b0,
        ARB_OWN_DATA = 1'b1
    } arb_owner_t;

    localparam logic [31:0] ARB_ABORT_DATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Pipeline-side and memory-side signals of the unified memory port arbiter.
// master = arbiter view, slave = pipeline/memory environment view; ARB_STATS_EN adds stall counters.
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic [DATA_W-1:0] if_rdata;
    logic              if_ready;
    logic              dm_ren;
    logic              dm_wen;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic [DATA_W-1:0] dm_rdata;
    logic              dm_ready;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;
    logic              mem_ack;
    logic              stall_if;
    logic              stall_mem;
    logic              err_timeout;
`ifdef ARB_STATS_EN
    logic [31:0]       stat_if_wait;
    logic [31:0]       stat_dm_wait;

    modport master (
        input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, err_timeout, stat_if_wait, stat_dm_wait
    );
    modport slave (
        output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err_timeout, stat_if_wait, stat_dm_wait
    );
`else
    modport master (
        input  if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
        output if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
        output stall_if, stall_mem, err_timeout
    );
    modport slave (
        output if_req, if_addr, dm_ren, dm_wen, dm_addr, dm_wdata, mem_rdata, mem_ack,
        input  if_rdata, if_ready, dm_rdata, dm_ready, mem_req, mem_we, mem_addr, mem_wdata,
        input  stall_if, stall_mem, err_timeout
    );
`endif
endinterface

// File: rtl/mem_arb_wait_timer.sv
// Wait-state watchdog: counts enabled cycles, expire flags the MAX_WAIT-th one.
// expire is combinational in the cycle the limit is hit; clr has priority over en.
module mem_arb_wait_timer #(
    parameter int MAX_WAIT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic expire
);
    localparam int CNT_W = $clog2(MAX_WAIT + 1);

    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    // cnt_q holds the number of earlier unacked cycles, so this cycle is number cnt_q+1
    assign expire = en && (cnt_q == CNT_W'(MAX_WAIT - 1));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates IF fetch vs MEM load/store onto one memory port; data side has fixed priority.
// Latency: ready 2 cycles after request seen in IDLE, +1 per memory wait state; requesters stall until ready.
// Optional ARB_STATS_EN adds saturating stall-cycle counters.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    mem_port_arbiter_if.master   bus
);
    arb_state_t        state_q, state_d;
    arb_owner_t        owner_q;
    logic              dm_any;
    logic              any_req;
    logic              tmr_clr;
    logic              tmr_en;
    logic              tmr_expire;
    logic [ADDR_W-1:0] grant_addr;
    logic [DATA_W-1:0] grant_wdata;

    assign dm_any      = bus.dm_ren | bus.dm_wen;
    assign any_req     = dm_any | bus.if_req;
    assign grant_addr  = dm_any ? bus.dm_addr : bus.if_addr;
    assign grant_wdata = dm_any ? bus.dm_wdata : '0;

    mem_arb_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .clk    (clk),
        .rst    (rst),
        .clr    (tmr_clr),
        .en     (tmr_en),
        .expire (tmr_expire)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ARB_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        tmr_clr = 1'b1;
        tmr_en  = 1'b0;
        unique case (state_q)
            ARB_IDLE: if (any_req) state_d = ARB_BUSY;
            ARB_BUSY: begin
                tmr_clr = 1'b0;
                tmr_en  = ~bus.mem_ack;
                if (bus.mem_ack || tmr_expire) state_d = ARB_DONE;
            end
            ARB_DONE: state_d = ARB_IDLE;
            default:  state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q         <= ARB_OWN_INST;
            bus.mem_we      <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_wdata   <= '0;
            bus.if_rdata    <= '0;
            bus.dm_rdata    <= '0;
            bus.err_timeout <= 1'b0;
        end else if (state_q == ARB_IDLE) begin
            if (any_req) begin
                owner_q       <= dm_any ? ARB_OWN_DATA : ARB_OWN_INST;
                bus.mem_we    <= bus.dm_wen;
                bus.mem_addr  <= grant_addr;
                bus.mem_wdata <= grant_wdata;
            end
        end else if (state_q == ARB_BUSY) begin
            // A late ack on the final allowed cycle still wins over the abort
            if (bus.mem_ack) begin
                if (!bus.mem_we) begin
                    if (owner_q == ARB_OWN_DATA) bus.dm_rdata <= bus.mem_rdata;
                    else                         bus.if_rdata <= bus.mem_rdata;
                end
            end else if (tmr_expire) begin
                bus.err_timeout <= 1'b1;
                if (owner_q == ARB_OWN_DATA) bus.dm_rdata <= DATA_W'(ARB_ABORT_DATA);
                else                         bus.if_rdata <= DATA_W'(ARB_ABORT_DATA);
            end
        end
    end

    assign bus.mem_req   = (state_q == ARB_BUSY);
    assign bus.if_ready  = (state_q == ARB_DONE) && (owner_q == ARB_OWN_INST);
    assign bus.dm_ready  = (state_q == ARB_DONE) && (owner_q == ARB_OWN_DATA);
    assign bus.stall_if  = bus.if_req & ~bus.if_ready;
    assign bus.stall_mem = dm_any & ~bus.dm_ready;

`ifdef ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.stat_if_wait <= '0;
            bus.stat_dm_wait <= '0;
        end else begin
            if (bus.stall_if  && (bus.stat_if_wait != '1)) bus.stat_if_wait <= bus.stat_if_wait + 32'd1;
            if (bus.stall_mem && (bus.stat_dm_wait != '1)) bus.stat_dm_wait <= bus.stat_dm_wait + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios plus random fetch/load/store traffic
// against a unified-memory model with expected latency, data and sticky error.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    localparam int MW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad   = 0;

    logic [31:0] mem_model [logic [31:0]];
    logic [31:0] exp_if_rdata = '0;
    logic [31:0] exp_dm_rdata = '0;
    logic        exp_err      = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input bit ok);
        total++;
        if (!ok) begin
            bad++;
            $error("FAIL %s", tag);
        end
    endtask

    // kind: 0 fetch, 1 load, 2 store; waits >= MW means the memory never acks
    task automatic xfer(input int kind, input logic [31:0] addr, input logic [31:0] wdata,
                        input int waits, input string tag);
        int          busy;
        bit          done;
        bit          tmo;
        logic [31:0] rv;
        logic [31:0] exp_rd;
        tmo  = (waits >= MW);
        rv   = mem_model.exists(addr) ? mem_model[addr] : $urandom;
        busy = 0;
        done = 1'b0;
        bus.if_req   = (kind == 0);
        bus.if_addr  = addr;
        bus.dm_ren   = (kind == 1);
        bus.dm_wen   = (kind == 2);
        bus.dm_addr  = addr;
        bus.dm_wdata = wdata;
        #1;
        chk({tag, "_stall0"}, ((kind == 0) ? bus.stall_if : bus.stall_mem) === 1'b1);
        for (int c = 0; c < MW + 3; c++) begin
            @(posedge clk); #1;
            bus.mem_ack = 1'b0;
            if (!bus.mem_req) begin
                done = 1'b1;
                break;
            end
            busy++;
            chk({tag, "_addr"}, bus.mem_addr === addr);
            chk({tag, "_we"}, bus.mem_we === (kind == 2));
            if (kind == 2) chk({tag, "_wdata"}, bus.mem_wdata === wdata);
            if (busy == 1) chk({tag, "_stall"}, ((kind == 0) ? bus.stall_if : bus.stall_mem) === 1'b1);
            if (!tmo && busy == waits + 1) begin
                bus.mem_ack   = 1'b1;
                bus.mem_rdata = rv;
            end
        end
        chk({tag, "_done"}, done === 1'b1);
        chk({tag, "_busy"}, busy === (tmo ? MW : waits + 1));
        if (tmo) begin
            exp_err = 1'b1;
            exp_rd  = ARB_ABORT_DATA;
        end else begin
            exp_rd = rv;
            if (kind == 2) mem_model[addr] = wdata;
        end
        if (kind == 0) exp_if_rdata = exp_rd;
        else if (kind == 1 || tmo) exp_dm_rdata = exp_rd;
        chk({tag, "_if_rdy"}, bus.if_ready === (kind == 0));
        chk({tag, "_dm_rdy"}, bus.dm_ready === (kind != 0));
        chk({tag, "_if_rd"}, bus.if_rdata === exp_if_rdata);
        chk({tag, "_dm_rd"}, bus.dm_rdata === exp_dm_rdata);
        chk({tag, "_err"}, bus.err_timeout === exp_err);
        chk({tag, "_nostall"}, (bus.stall_if | bus.stall_mem) === 1'b0);
        bus.if_req = 1'b0;
        bus.dm_ren = 1'b0;
        bus.dm_wen = 1'b0;
        @(posedge clk); #1;
        chk({tag, "_rdy_off"}, {bus.if_ready, bus.dm_ready, bus.mem_req} === 3'b000);
    endtask

    initial begin
        logic [31:0] rv1;
        logic [31:0] rv2;
        int          kind;
        int          waits;
        logic [31:0] addr;
`ifdef ARB_STATS_EN
        logic [31:0] stat0;
`endif
        bus.if_req = 1'b0; bus.if_addr = '0;
        bus.dm_ren = 1'b0; bus.dm_wen = 1'b0; bus.dm_addr = '0; bus.dm_wdata = '0;
        bus.mem_ack = 1'b0; bus.mem_rdata = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_req", bus.mem_req === 1'b0);
        chk("rst_we", bus.mem_we === 1'b0);
        chk("rst_rdy", {bus.if_ready, bus.dm_ready} === 2'b00);
        chk("rst_err", bus.err_timeout === 1'b0);
        chk("rst_addr", bus.mem_addr === 32'h0);
        chk("rst_wdata", bus.mem_wdata === 32'h0);
        chk("rst_ifrd", bus.if_rdata === 32'h0);
        chk("rst_dmrd", bus.dm_rdata === 32'h0);
        rst = 1'b0;

        mem_model[32'h40] = 32'h2008_0005;
        xfer(0, 32'h40, 32'h0, 0, "fetch40");
        xfer(2, 32'h104, 32'hCAFE_F00D, 3, "store104");
        xfer(1, 32'h104, 32'h0, 1, "load104");

        // fetch and load together: data goes first, fetch waits behind it
        mem_model[32'h100] = 32'h1111_2222;
        mem_model[32'h80]  = 32'h3333_4444;
        rv1 = mem_model[32'h100];
        rv2 = mem_model[32'h80];
`ifdef ARB_STATS_EN
        stat0 = bus.stat_if_wait;
`endif
        bus.if_req = 1'b1; bus.if_addr = 32'h80;
        bus.dm_ren = 1'b1; bus.dm_addr = 32'h100;
        #1;
        chk("both_stall_if0", bus.stall_if === 1'b1);
        @(posedge clk); #1;
        chk("both_addr_d", bus.mem_addr === 32'h100);
        chk("both_we_d", bus.mem_we === 1'b0);
        chk("both_stall_if1", bus.stall_if === 1'b1);
        bus.mem_ack = 1'b1; bus.mem_rdata = rv1;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("both_dm_rdy", {bus.dm_ready, bus.if_ready} === 2'b10);
        chk("both_dm_rd", bus.dm_rdata === rv1);
        chk("both_stall_if2", bus.stall_if === 1'b1);
        exp_dm_rdata = rv1;
        bus.dm_ren = 1'b0;
        @(posedge clk); #1;
        chk("both_idle", bus.mem_req === 1'b0);
        chk("both_stall_if3", bus.stall_if === 1'b1);
        @(posedge clk); #1;
        chk("both_addr_i", bus.mem_addr === 32'h80);
        chk("both_stall_if4", bus.stall_if === 1'b1);
        bus.mem_ack = 1'b1; bus.mem_rdata = rv2;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("both_if_rdy", {bus.dm_ready, bus.if_ready} === 2'b01);
        chk("both_if_rd", bus.if_rdata === rv2);
        chk("both_stall_if5", bus.stall_if === 1'b0);
        exp_if_rdata = rv2;
        bus.if_req = 1'b0;
        @(posedge clk); #1;
`ifdef ARB_STATS_EN
        chk("stat_if_wait", (bus.stat_if_wait - stat0) === 32'd5);
`endif

        for (int i = 0; i < 30; i++) begin
            kind  = $urandom_range(0, 2);
            waits = $urandom_range(0, 3);
            addr  = 32'h200 + 32'($urandom_range(0, 7)) * 32'd4;
            xfer(kind, addr, $urandom, waits, "rand");
        end

        xfer(1, 32'h300, 32'h0, MW, "timeout");
        xfer(0, 32'h40, 32'h0, 0, "after_tmo");

        // reset during BUSY aborts the transfer and clears the sticky error
        bus.dm_ren = 1'b1; bus.dm_addr = 32'h500;
        @(posedge clk); #1;
        chk("rstbusy_req", bus.mem_req === 1'b1);
        rst = 1'b1;
        bus.dm_ren = 1'b0;
        @(posedge clk); #1;
        chk("rstbusy_req0", bus.mem_req === 1'b0);
        chk("rstbusy_err", bus.err_timeout === 1'b0);
        chk("rstbusy_dmrd", bus.dm_rdata === 32'h0);
        exp_err = 1'b0; exp_dm_rdata = '0; exp_if_rdata = '0;
        rst = 1'b0;
        bus.mem_ack = 1'b1; bus.mem_rdata = 32'h1234_5678;
        @(posedge clk); #1;
        bus.mem_ack = 1'b0;
        chk("late_ack_req", bus.mem_req === 1'b0);
        chk("late_ack_rdy", {bus.if_ready, bus.dm_ready} === 2'b00);
        @(posedge clk); #1;
        chk("late_ack_rdy2", {bus.if_ready, bus.dm_ready} === 2'b00);
        chk("late_ack_dmrd", bus.dm_rdata === 32'h0);
        xfer(0, 32'h40, 32'h0, 2, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
